// File: rtl/wb_pkg.sv
// Shared types and default widths for the Wishbone-style command initiator.
package wb_pkg;

  localparam int unsigned DefAddrW     = 8;
  localparam int unsigned DefDataW     = 8;
  localparam int unsigned DefFifoDepth = 4;
  localparam int unsigned DefTimeout   = 16;

  typedef enum logic [1:0] {IDLE, REQ, RESP} wbm_state_t;

  typedef struct packed {
    logic                wr;
    logic [DefAddrW-1:0] addr;
    logic [DefDataW-1:0] wdata;
  } wb_cmd_t;

endpackage

// File: rtl/wb_cmd_fifo.sv
// Synchronous command FIFO; pointers carry one extra wrap bit to tell full from empty.
module wb_cmd_fifo #(
  parameter int unsigned Width = 17,
  parameter int unsigned Depth = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [Width-1:0] wdata,
  output logic             full,
  input  logic             pop,
  output logic [Width-1:0] rdata,
  output logic             empty
);

  localparam int unsigned PtrW = $clog2(Depth);

  logic [Width-1:0] mem [Depth];
  logic [PtrW:0]    wptr_q, rptr_q;
  logic             do_push, do_pop;

  assign empty   = (wptr_q == rptr_q);
  assign full    = (wptr_q[PtrW] != rptr_q[PtrW]) && (wptr_q[PtrW-1:0] == rptr_q[PtrW-1:0]);
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees a slot, so a push while full is accepted then.
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rptr_q[PtrW-1:0]];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + (PtrW+1)'(1);
      if (do_pop)  rptr_q <= rptr_q + (PtrW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr_q[PtrW-1:0]] <= wdata;
  end

endmodule

// File: rtl/wb_master_ctrl.sv
// Wishbone-style initiator: queued commands become single bus transactions, each
// answered by exactly one response; a saturating counter aborts unacknowledged strobes.
module wb_master_ctrl
  import wb_pkg::*;
#(
  parameter int unsigned ADDR_W     = DefAddrW,
  parameter int unsigned DATA_W     = DefDataW,
  parameter int unsigned FIFO_DEPTH = DefFifoDepth,
  parameter int unsigned TIMEOUT    = DefTimeout
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_wr,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_wr,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              wr,
  output logic              strb,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] rdata,
  input  logic              ack,
  output logic              busy
);

  localparam int unsigned   CntW    = $clog2(TIMEOUT);
  localparam int unsigned   CmdW    = 1 + ADDR_W + DATA_W;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

  wbm_state_t       state_q;
  logic [CntW-1:0]  cnt_q;
  logic [CmdW-1:0]  head;
  logic             fifo_full, fifo_empty, pop;

  assign cmd_ready = !fifo_full;
  assign pop       = (state_q == IDLE) && !fifo_empty;
  assign busy      = !fifo_empty || (state_q != IDLE);

  wb_cmd_fifo #(
    .Width (CmdW),
    .Depth (FIFO_DEPTH)
  ) u_cmd_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (cmd_valid && cmd_ready),
    .wdata ({cmd_wr, cmd_addr, cmd_wdata}),
    .full  (fifo_full),
    .pop   (pop),
    .rdata (head),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      strb      <= 1'b0;
      wr        <= 1'b0;
      addr      <= '0;
      wdata     <= '0;
      rsp_valid <= 1'b0;
      rsp_wr    <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (!fifo_empty) begin
            strb    <= 1'b1;
            wr      <= head[CmdW-1];
            addr    <= head[ADDR_W+DATA_W-1:DATA_W];
            wdata   <= head[DATA_W-1:0];
            cnt_q   <= '0;
            state_q <= REQ;
          end
        end
        REQ: begin
          // ack takes priority over a timeout landing on the same edge.
          if (ack) begin
            strb      <= 1'b0;
            wr        <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_wr    <= wr;
            rsp_rdata <= wr ? '0 : rdata;
            rsp_err   <= 1'b0;
            state_q   <= RESP;
          end else if (cnt_q == CntLast) begin
            strb      <= 1'b0;
            wr        <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_wr    <= wr;
            rsp_rdata <= '0;
            rsp_err   <= 1'b1;
            state_q   <= RESP;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state_q   <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
